// File: rtl/tile_attr_fetch_if.sv
// Video-RAM read port between tile_attr_fetch (master) and the memory arbiter (slave).
// The req/gnt/rvalid protocol allows one read in flight per grant.
interface tile_attr_fetch_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/tile_attr_fetch.sv
// Prefetches tile and palette codes for the next 8x8 tile; presents them at tile boundaries.
// Optional saturating underrun counter when TILE_FETCH_STATS_EN is defined.
module tile_attr_fetch #(
    parameter int unsigned TILES_X      = 28,
    parameter int unsigned TILES_Y      = 36,
    parameter int unsigned V_TOTAL      = 525,
    parameter logic [15:0] TILE_BASE    = 16'h4000,
    parameter logic [15:0] PALETTE_BASE = 16'h4400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic [8:0]        row,
    input  logic [9:0]        col,
    tile_attr_fetch_if.master mem,
    output logic [7:0]        tile_ROM_addr,
    output logic [5:0]        palette_ROM_addr,
    output logic              underrun
`ifdef TILE_FETCH_STATS_EN
    ,
    output logic [15:0]       underrun_count
`endif
);

    typedef enum logic [2:0] {IDLE, REQ_T, WAIT_T, REQ_P, WAIT_P, DONE} state_t;

    state_t     state;
    logic [9:0] raw_q;
    logic [7:0] shadow_tile;
    logic [5:0] shadow_pal;
    logic       pending;
    logic       discard;

    logic       trigger;
    logic       boundary;
    logic       busy;
    logic       start;
    logic       wrap;
    logic       off_screen;
    logic [6:0] cur_tc;
    logic [8:0] next_row;
    logic [5:0] tgt_tr;
    logic [6:0] tgt_tc;
    logic [9:0] tgt_raw;

    assign trigger  = pix_en && (col[2:0] == 3'd0);
    assign boundary = pix_en && (col[2:0] == 3'd7);
    assign busy     = state inside {REQ_T, WAIT_T, REQ_P, WAIT_P};

    // Last tile of a line prefetches tile 0 of the following line.
    assign cur_tc     = col[9:3];
    assign next_row   = (32'(row) == V_TOTAL - 1) ? 9'd0 : row + 9'd1;
    assign wrap       = (32'(cur_tc) + 32'd1) >= TILES_X;
    assign tgt_tr     = wrap ? next_row[8:3] : row[8:3];
    assign tgt_tc     = wrap ? 7'd0 : cur_tc + 7'd1;
    assign tgt_raw    = 10'(32'(tgt_tr) * TILES_X + 32'(tgt_tc));
    assign off_screen = 32'(tgt_tr) >= TILES_Y;

    // A pending trigger is not serviced on the boundary edge itself: col still
    // points at the outgoing tile there, so the recomputed target would be stale.
    assign start = (state == DONE && trigger) ||
                   (state == IDLE && (trigger || pending) && !boundary);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            raw_q            <= '0;
            shadow_tile      <= '0;
            shadow_pal       <= '0;
            pending          <= 1'b0;
            discard          <= 1'b0;
            mem.mem_req      <= 1'b0;
            mem.mem_addr     <= '0;
            tile_ROM_addr    <= '0;
            palette_ROM_addr <= '0;
            underrun         <= 1'b0;
        end else begin
            underrun <= 1'b0;

            if (boundary) begin
                if (state == DONE) begin
                    tile_ROM_addr    <= shadow_tile;
                    palette_ROM_addr <= shadow_pal;
                end else begin
                    tile_ROM_addr    <= '0;
                    palette_ROM_addr <= '0;
                    underrun         <= 1'b1;
                    if (busy) discard <= 1'b1;
                end
            end

            if (trigger && busy) pending <= 1'b1;

            // NOTE: with non-blocking assignments the last one in program order wins,
            // so the case arms below may override flags set by the boundary logic above.
            case (state)
                IDLE, DONE: begin
                    if (boundary && state == DONE) begin
                        state <= IDLE;
                    end else if (start) begin
                        pending <= 1'b0;
                        if (off_screen) begin
                            shadow_tile <= '0;
                            shadow_pal  <= '0;
                            state       <= DONE;
                        end else begin
                            raw_q        <= tgt_raw;
                            mem.mem_req  <= 1'b1;
                            mem.mem_addr <= TILE_BASE + {6'd0, tgt_raw};
                            state        <= REQ_T;
                        end
                    end
                end
                REQ_T: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        state       <= WAIT_T;
                    end
                end
                WAIT_T: begin
                    if (mem.mem_rvalid) begin
                        shadow_tile  <= mem.mem_rdata;
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= PALETTE_BASE + {6'd0, raw_q};
                        state        <= REQ_P;
                    end
                end
                REQ_P: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        state       <= WAIT_P;
                    end
                end
                WAIT_P: begin
                    if (mem.mem_rvalid) begin
                        if (discard || boundary) begin
                            discard <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            shadow_pal <= mem.mem_rdata[5:0];
                            state      <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TILE_FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_count <= '0;
        end else if (underrun && underrun_count != 16'hFFFF) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule
